// File: rtl/frame_bank_scheduler_pkg.sv
// Shared definitions for the frame-buffer bank scheduler.
//   bank_t              : index of one of the frame RAM banks
//   FRAME_WORDS_DEFAULT : words per bank (320x240 pixels, one 16-bit word each)
//   RST_*_BANK          : bank roles taken out of reset
//   bank_base()         : first RAM word of a bank
package frame_bank_scheduler_pkg;

  localparam int unsigned NUM_BANKS           = 3;
  localparam int unsigned FRAME_WORDS_DEFAULT = 76800;

  typedef logic [$clog2(NUM_BANKS)-1:0] bank_t;

  localparam bank_t RST_WR_BANK    = 2'd0;
  localparam bank_t RST_RD_BANK    = 2'd1;
  localparam bank_t RST_SPARE_BANK = 2'd2;

  function automatic int unsigned bank_base(input bank_t bank, input int unsigned frame_words);
    return {30'd0, bank} * frame_words;
  endfunction

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Capture/VGA side bus of the frame-buffer bank scheduler.
//   master : capture stage and VGA scanner (drive frame markers and pixels)
//   slave  : the scheduler (drives RAM port-A write strobe/address and port-B base)
interface frame_bank_scheduler_if #(
  parameter int ADDR_W = 18
);
  logic              wr_sof;
  logic              wr_eof;
  logic              wr_pix_valid;
  logic [ADDR_W-1:0] wr_pix_addr;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_sof;
  logic [ADDR_W-1:0] rd_base;

  modport master (
    output wr_sof, wr_eof, wr_pix_valid, wr_pix_addr, rd_sof,
    input  wr_we, wr_addr, rd_base
  );

  modport slave (
    input  wr_sof, wr_eof, wr_pix_valid, wr_pix_addr, rd_sof,
    output wr_we, wr_addr, rd_base
  );
endinterface

// File: rtl/frame_bank_scheduler_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
//   clk   : clock
//   clear : synchronous clear (takes priority over inc)
//   inc   : count one event this cycle
//   count : current value
module frame_bank_scheduler_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clear)    count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler for the camera frame RAM. One bank is written by capture,
// one is shown by VGA, the third holds the newest complete frame (or is spare), so
// the display never shows a torn frame.
//   clk_25          : single clock
//   rst_n           : synchronous active-low reset
//   bus (slave)     : frame markers / pixels in; port-A we/address and port-B base out
//   wr_bank/rd_bank : bank being written / displayed
//   ready_valid     : spare bank holds a complete frame not yet shown
//   frames_dropped  : complete frames overwritten before display (saturating)
//   frames_repeated : rd_sof with no new frame available (saturating)
module frame_bank_scheduler
  import frame_bank_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int          ADDR_W      = 18,
  parameter int          CNT_W       = 16
) (
  input  logic                   clk_25,
  input  logic                   rst_n,
  frame_bank_scheduler_if.slave  bus,
  output bank_t                  wr_bank,
  output bank_t                  rd_bank,
  output logic                   ready_valid,
  output logic [CNT_W-1:0]       frames_dropped,
  output logic [CNT_W-1:0]       frames_repeated
);

  bank_t             spare_bank;
  logic              wr_active;
  logic [ADDR_W-1:0] rd_base_q;
  logic [ADDR_W-1:0] wr_base;

  bank_t wr_bank_n, rd_bank_n, spare_bank_n;
  logic  ready_valid_n, wr_active_n;
  logic  drop_inc, repeat_inc;
  logic  eof_hit;

  assign wr_base     = ADDR_W'(bank_base(wr_bank, FRAME_WORDS));
  assign bus.wr_we   = wr_active & bus.wr_pix_valid;
  assign bus.wr_addr = wr_base + bus.wr_pix_addr;
  assign bus.rd_base = rd_base_q;

  // An eof only counts while a frame is open; a stray eof is ignored.
  assign eof_hit = bus.wr_eof & wr_active;

  always_comb begin
    wr_bank_n     = wr_bank;
    rd_bank_n     = rd_bank;
    spare_bank_n  = spare_bank;
    ready_valid_n = ready_valid;
    wr_active_n   = wr_active;
    drop_inc      = 1'b0;
    repeat_inc    = 1'b0;

    if (eof_hit && bus.rd_sof) begin
      // Frame finishing exactly at vblank goes straight to the display.
      rd_bank_n = wr_bank;
      if (ready_valid) begin
        wr_bank_n    = spare_bank;
        spare_bank_n = rd_bank;
        drop_inc     = 1'b1;
      end else begin
        wr_bank_n    = rd_bank;
      end
      ready_valid_n = 1'b0;
      wr_active_n   = 1'b0;
    end else begin
      if (eof_hit) begin
        wr_bank_n     = spare_bank;
        spare_bank_n  = wr_bank;
        ready_valid_n = 1'b1;
        wr_active_n   = 1'b0;
        drop_inc      = ready_valid;
      end
      if (bus.rd_sof) begin
        if (ready_valid) begin
          rd_bank_n     = spare_bank;
          spare_bank_n  = rd_bank;
          ready_valid_n = 1'b0;
        end else begin
          repeat_inc    = 1'b1;
        end
      end
    end

    // sof is applied after eof, so a same-cycle eof+sof closes one frame and opens
    // the next; a sof with the frame still open restarts it in place.
    if (bus.wr_sof) begin
      if (wr_active_n) drop_inc = 1'b1;
      wr_active_n = 1'b1;
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      wr_bank     <= RST_WR_BANK;
      rd_bank     <= RST_RD_BANK;
      spare_bank  <= RST_SPARE_BANK;
      ready_valid <= 1'b0;
      wr_active   <= 1'b0;
      rd_base_q   <= ADDR_W'(FRAME_WORDS);
    end else begin
      wr_bank     <= wr_bank_n;
      rd_bank     <= rd_bank_n;
      spare_bank  <= spare_bank_n;
      ready_valid <= ready_valid_n;
      wr_active   <= wr_active_n;
      rd_base_q   <= ADDR_W'(bank_base(rd_bank_n, FRAME_WORDS));
    end
  end

  frame_bank_scheduler_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk_25),
    .clear (!rst_n),
    .inc   (drop_inc),
    .count (frames_dropped)
  );

  frame_bank_scheduler_sat_counter #(.CNT_W(CNT_W)) u_repeat_cnt (
    .clk   (clk_25),
    .clear (!rst_n),
    .inc   (repeat_inc),
    .count (frames_repeated)
  );

endmodule
